lif_stdp_pair: RTL and testbench
================================

# lif_stdp_pair

Parametrised pre/post leaky-integrate-and-fire neuron pair joined by one plastic synapse, the next generation of the single-neuron demo. It adds configurable width, threshold, leak and refractory period to each neuron. The synapse weight is learned on-chip by a windowed STDP rule and can be loaded externally. It sits behind the tile top, driven from the input switches, with spikes, membrane states and weight brought out for observation.

## Interface
- W, 8: membrane/current width in bits
- WW, 8: weight width in bits; WW <= W
- THRESH, 200: firing threshold
- LEAK_SHIFT, 1: leak per cycle = state >> LEAK_SHIFT
- REFRAC, 4: refractory cycles after a spike; 0 = none
- WIN, 15: STDP window in cycles; counters saturate at WIN
- W_INIT, 32: weight after reset
- W_MAX, 2^WW-1: weight upper clamp
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- current  in  W  pre-neuron input current, sampled every cycle
- learn_en  in  1  enables STDP weight updates
- w_load  in  1  load weight from w_load_val this edge
- w_load_val  in  WW  weight to load; values above W_MAX clamp to W_MAX
- spike_pre  out  1  pre-neuron spike, one-cycle pulse
- spike_post  out  1  post-neuron spike, one-cycle pulse
- state_pre  out  W  pre membrane
- state_post  out  W  post membrane
- weight  out  WW  current synaptic weight

## Operation
- Reset: state_pre = state_post = 0, spikes = 0, refractory counters = 0, t_pre = t_post = WIN, weight = W_INIT.
- Neuron update, per edge, when not refractory: nxt = state - (state >> LEAK_SHIFT) + in. Compute in W+1 bits and saturate to 2^W-1.
- If nxt >= THRESH: spike <= 1, state <= 0, refractory counter <= REFRAC. Otherwise state <= nxt and spike <= 0.
- While the refractory counter is nonzero: state held 0, input ignored, no spike, counter decrements.
- Pre input = current. Post input = spike_pre ? zero-extended weight : 0.
- t_pre / t_post: cleared to 0 on the edge that asserts the matching spike. Otherwise they increment, saturating at WIN.
- On the edge following a cycle where spike_post=1, learn_en=1 and t_pre < WIN: weight <= min(W_MAX, weight + (WIN - t_pre)). This is potentiation.
- On the edge following a cycle where spike_pre=1, learn_en=1 and t_post < WIN: weight <= max(0, weight - (WIN - t_post)). This is depression.
- spike_pre and spike_post both high in the same cycle: weight unchanged.
- Priority order: rst > w_load > STDP. A w_load in a cycle that also carries an STDP update discards the update.

## Timing
- Spike latency: the spike asserts on the same edge that registers the threshold crossing, and is high for exactly one cycle.
- Pre-to-post: the minimum latency from spike_pre high to spike_post high is 1 cycle.
- Weight update: lands 1 cycle after the triggering spike cycle. The post input uses the weight value present in the spike_pre cycle.
- Firing period: with saturating drive, the inter-spike period = REFRAC + 1 cycles.
- rst mid-refractory or mid-update: everything returns to reset values on that edge, and any pending update is dropped.

## Configuration
- LIF_STDP_LEARN_EN defined: t_pre/t_post counters and STDP update logic are built, behaving as described above.
- LIF_STDP_LEARN_EN undefined: no counters or STDP logic are built, and learn_en is ignored. The weight changes only via reset (W_INIT) or w_load.

## Structure
- Shared package lif_stdp_pkg holds:
  - a saturating add/subtract function
  - the weight clamp function
  - default parameter constants
- Sub-module lif_neuron_p holds one neuron: membrane, leak, threshold, refractory counter and spike register. It is instantiated twice.
- The top holds the synapse mux, the STDP counters and the weight register.

## Test plan
- Reset: assert rst for 2 cycles with current=255 -> all outputs 0, weight=32, no spike during reset.
- Drive current=255 with defaults -> spike_pre on the first edge after reset release, then every 5 cycles; state_pre=0 during refractory.
- current=0 -> no spikes for 100 cycles; weight stays 32 with learn_en=1.
- Potentiation:
  - w_load 220, learn_en=1, current=255.
  - Expect spike_post 1 cycle after spike_pre (t_pre=1), then weight=234.
  - On the next spike_pre (t_post=4), expect weight=223.
- Clamp: w_load_val=255 with potentiation -> weight stays 255; w_load_val=2 with depression of 11 -> weight=0.
- Priority: w_load=1 in the same cycle as an STDP trigger -> weight = w_load_val. With LIF_STDP_LEARN_EN undefined -> the weight never moves except on load/reset.

Source files
------------

// File: rtl/lif_stdp_pkg.sv
// Shared constants and saturating arithmetic helpers for the LIF/STDP neuron pair.
package lif_stdp_pkg;

  localparam int unsigned DefW          = 8;
  localparam int unsigned DefWw         = 8;
  localparam int unsigned DefThresh     = 200;
  localparam int unsigned DefLeakShift  = 1;
  localparam int unsigned DefRefrac     = 4;
  localparam int unsigned DefWin        = 15;
  localparam int unsigned DefWInit      = 32;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

  // Floors at zero rather than wrapping.
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] max_val);
    return (v > max_val) ? max_val : v;
  endfunction

endpackage

// File: rtl/lif_neuron_p.sv
// One leaky-integrate-and-fire neuron: membrane, leak, threshold, refractory counter
// and registered one-cycle spike. fire is the spike next-state, for edge-aligned counters.
module lif_neuron_p
  import lif_stdp_pkg::*;
#(
  parameter int unsigned W          = DefW,
  parameter int unsigned THRESH     = DefThresh,
  parameter int unsigned LEAK_SHIFT = DefLeakShift,
  parameter int unsigned REFRAC     = DefRefrac
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_cur,
  output logic         fire,
  output logic         spike,
  output logic [W-1:0] state
);

  localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [31:0] StateMax = 32'((64'd1 << W) - 64'd1);

  logic [W-1:0]  state_q, state_d, leaked;
  logic [RW-1:0] refrac_q, refrac_d;
  logic          spike_q, spike_d;
  logic [31:0]   nxt;

  always_comb begin
    leaked   = state_q - (state_q >> LEAK_SHIFT);
    nxt      = sat_add(32'(leaked), 32'(in_cur), StateMax);
    state_d  = '0;
    spike_d  = 1'b0;
    refrac_d = refrac_q;
    // Refractory: membrane clamped to zero and input ignored until the counter drains.
    if (refrac_q != '0) begin
      refrac_d = refrac_q - RW'(1);
    end else if (nxt >= 32'(THRESH)) begin
      spike_d  = 1'b1;
      refrac_d = RW'(REFRAC);
    end else begin
      state_d = W'(nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= '0;
      refrac_q <= '0;
      spike_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      refrac_q <= refrac_d;
      spike_q  <= spike_d;
    end
  end

  assign fire  = spike_d;
  assign spike = spike_q;
  assign state = state_q;

endmodule

// File: rtl/lif_stdp_pair.sv
// Pre/post LIF neuron pair joined by one plastic synapse with loadable weight.
// Define LIF_STDP_LEARN_EN to build the windowed STDP counters and update logic.
module lif_stdp_pair
  import lif_stdp_pkg::*;
#(
  parameter int unsigned W          = DefW,
  parameter int unsigned WW         = DefWw,
  parameter int unsigned THRESH     = DefThresh,
  parameter int unsigned LEAK_SHIFT = DefLeakShift,
  parameter int unsigned REFRAC     = DefRefrac,
  parameter int unsigned WIN        = DefWin,
  parameter int unsigned W_INIT     = DefWInit,
  parameter int unsigned W_MAX      = (32'd1 << WW) - 32'd1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  current,
  input  logic          learn_en,
  input  logic          w_load,
  input  logic [WW-1:0] w_load_val,
  output logic          spike_pre,
  output logic          spike_post,
  output logic [W-1:0]  state_pre,
  output logic [W-1:0]  state_post,
  output logic [WW-1:0] weight
);

  logic          fire_pre, fire_post;
  logic [W-1:0]  post_in;
  logic [WW-1:0] weight_q, weight_d, stdp_w;

  lif_neuron_p #(
    .W          (W),
    .THRESH     (THRESH),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRAC     (REFRAC)
  ) u_pre (
    .clk    (clk),
    .rst    (rst),
    .in_cur (current),
    .fire   (fire_pre),
    .spike  (spike_pre),
    .state  (state_pre)
  );

  // Post neuron sees the weight as it stands in the spike_pre cycle.
  assign post_in = spike_pre ? W'(weight_q) : '0;

  lif_neuron_p #(
    .W          (W),
    .THRESH     (THRESH),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRAC     (REFRAC)
  ) u_post (
    .clk    (clk),
    .rst    (rst),
    .in_cur (post_in),
    .fire   (fire_post),
    .spike  (spike_post),
    .state  (state_post)
  );

`ifdef LIF_STDP_LEARN_EN
  localparam int unsigned TW = $clog2(WIN + 1);

  logic [TW-1:0] t_pre_q, t_pre_d, t_post_q, t_post_d;

  always_comb begin
    t_pre_d  = fire_pre ? '0 : ((t_pre_q == TW'(WIN)) ? t_pre_q : t_pre_q + TW'(1));
    t_post_d = fire_post ? '0 : ((t_post_q == TW'(WIN)) ? t_post_q : t_post_q + TW'(1));
    stdp_w   = weight_q;
    // Coincident spikes cancel: neither branch fires when both are high.
    if (learn_en && spike_post && !spike_pre && (t_pre_q < TW'(WIN))) begin
      stdp_w = WW'(sat_add(32'(weight_q), WIN - 32'(t_pre_q), W_MAX));
    end else if (learn_en && spike_pre && !spike_post && (t_post_q < TW'(WIN))) begin
      stdp_w = WW'(sat_sub(32'(weight_q), WIN - 32'(t_post_q)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_pre_q  <= TW'(WIN);
      t_post_q <= TW'(WIN);
    end else begin
      t_pre_q  <= t_pre_d;
      t_post_q <= t_post_d;
    end
  end
`else
  logic unused_learn;

  assign stdp_w       = weight_q;
  assign unused_learn = ^{learn_en, fire_pre, fire_post};
`endif

  always_comb begin
    weight_d = stdp_w;
    if (w_load) begin
      weight_d = WW'(clamp(32'(w_load_val), W_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      weight_q <= WW'(W_INIT);
    end else begin
      weight_q <= weight_d;
    end
  end

  assign weight = weight_q;

endmodule

// File: tb/tb_lif_stdp_pair.sv
// Scoreboard bench for lif_stdp_pair: the driver queues per-edge expectations, a negedge
// monitor compares whichever fall due. Expected weights follow LIF_STDP_LEARN_EN.
module tb_lif_stdp_pair;

`ifdef LIF_STDP_LEARN_EN
  localparam bit Learn = 1'b1;
`else
  localparam bit Learn = 1'b0;
`endif

  localparam int SelSpre  = 0;
  localparam int SelSpost = 1;
  localparam int SelStPre = 2;
  localparam int SelStPst = 3;
  localparam int SelWgt   = 4;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] current;
  logic       learn_en;
  logic       w_load;
  logic [7:0] w_load_val;
  logic       spike_pre, spike_post;
  logic [7:0] state_pre, state_post;
  logic [7:0] weight;

  exp_t sb[$];
  int   edges  = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  lif_stdp_pair dut (
    .clk        (clk),
    .rst        (rst),
    .current    (current),
    .learn_en   (learn_en),
    .w_load     (w_load),
    .w_load_val (w_load_val),
    .spike_pre  (spike_pre),
    .spike_post (spike_post),
    .state_pre  (state_pre),
    .state_post (state_post),
    .weight     (weight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      SelSpre:  return 32'(spike_pre);
      SelSpost: return 32'(spike_post);
      SelStPre: return 32'(state_pre);
      SelStPst: return 32'(state_post);
      default:  return 32'(weight);
    endcase
  endfunction

  // Monitor: compare every queued expectation that falls due after this edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == edges) begin
        n_cmp++;
        if (pick(sb[i].sel) !== sb[i].val) begin
          n_bad++;
          $display("FAIL %s @edge %0d: got %0d, want %0d", sb[i].name, edges,
                   pick(sb[i].sel), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int dc, input int sel, input logic [31:0] val,
                           input string name);
    exp_t e;
    e.cyc  = edges + dc;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    current    = 8'd255;
    learn_en   = 1'b0;
    w_load     = 1'b0;
    w_load_val = 8'd0;

    // Reset held two edges with full drive: nothing fires, weight at its init value.
    for (int k = 1; k <= 2; k++) begin
      expect_at(k, SelSpre, 0, "rst_spike_pre");
      expect_at(k, SelSpost, 0, "rst_spike_post");
      expect_at(k, SelStPre, 0, "rst_state_pre");
      expect_at(k, SelStPst, 0, "rst_state_post");
      expect_at(k, SelWgt, 32, "rst_weight");
    end
    step(2);
    n_cmp++;
    if (spike_pre !== 1'b0 || weight !== 8'd32) begin
      n_bad++;
      $display("FAIL direct_rst: spike_pre=%0b weight=%0d", spike_pre, weight);
    end

    // Saturating drive: spike on first edge, period REFRAC+1 = 5.
    rst = 1'b0;
    expect_at(1, SelSpre, 1, "drive_first_spike");
    expect_at(1, SelStPst, 0, "drive_post_d1");
    for (int k = 2; k <= 5; k++) begin
      expect_at(k, SelSpre, 0, "drive_refrac_spike");
      expect_at(k, SelStPre, 0, "drive_refrac_state");
    end
    expect_at(2, SelStPst, 32, "drive_post_int");
    expect_at(3, SelStPst, 16, "drive_post_leak");
    expect_at(6, SelSpre, 1, "drive_second_spike");
    expect_at(11, SelSpre, 1, "drive_third_spike");
    expect_at(11, SelWgt, 32, "drive_weight");
    step(11);

    // Quiet input with learning on: no spikes, weight untouched.
    current  = 8'd0;
    learn_en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      expect_at(k, SelSpre, 0, "quiet_spike_pre");
      expect_at(k, SelSpost, 0, "quiet_spike_post");
    end
    expect_at(100, SelWgt, 32, "quiet_weight");
    expect_at(100, SelStPre, 0, "quiet_state_pre");
    step(100);
    n_cmp++;
    if (weight !== 8'd32) begin
      n_bad++;
      $display("FAIL direct_quiet_weight: got %0d, want 32", weight);
    end

    // Potentiation then depression around a loaded weight of 220.
    w_load     = 1'b1;
    w_load_val = 8'd220;
    expect_at(1, SelWgt, 220, "pot_load");
    step(1);
    w_load  = 1'b0;
    current = 8'd255;
    expect_at(1, SelSpre, 1, "pot_pre_spike");
    expect_at(2, SelSpost, 1, "pot_post_spike");
    expect_at(2, SelWgt, 220, "pot_weight_before");
    expect_at(3, SelWgt, Learn ? 234 : 220, "pot_weight_up");
    expect_at(3, SelStPre, 0, "pot_state_refrac");
    expect_at(6, SelSpre, 1, "dep_pre_spike");
    expect_at(7, SelSpost, 1, "dep_post_spike");
    expect_at(7, SelWgt, Learn ? 223 : 220, "dep_weight_down");
    expect_at(8, SelWgt, Learn ? 237 : 220, "pot2_weight_up");
    step(6);
    current = 8'd0;
    expect_at(13, SelWgt, Learn ? 237 : 220, "pot_weight_settled");
    step(20);

    // Upper clamp: potentiation from 255 stays at 255.
    w_load     = 1'b1;
    w_load_val = 8'd255;
    expect_at(1, SelWgt, 255, "clamp_hi_load");
    step(1);
    w_load  = 1'b0;
    current = 8'd255;
    expect_at(1, SelSpre, 1, "clamp_hi_pre");
    expect_at(2, SelSpost, 1, "clamp_hi_post");
    expect_at(3, SelWgt, 255, "clamp_hi_weight");
    step(3);
    current = 8'd0;
    step(15);

    // Load beats a pending potentiation; then depression of 11 floors 2 at 0.
    current = 8'd255;
    expect_at(1, SelSpre, 1, "prio_pre");
    expect_at(2, SelSpost, 1, "prio_post");
    expect_at(3, SelWgt, 2, "prio_load_wins");
    expect_at(6, SelWgt, 2, "clamp_lo_before");
    expect_at(6, SelSpre, 1, "clamp_lo_pre");
    expect_at(7, SelWgt, Learn ? 0 : 2, "clamp_lo_weight");
    expect_at(7, SelSpost, 0, "clamp_lo_no_post");
    step(2);
    w_load     = 1'b1;
    w_load_val = 8'd2;
    step(1);
    w_load = 1'b0;
    step(4);
    current = 8'd0;
    step(15);

    // Reset mid-refractory: everything back to reset values, refractory dropped.
    current = 8'd255;
    expect_at(1, SelSpre, 1, "mid_rst_spike");
    step(1);
    rst = 1'b1;
    expect_at(1, SelWgt, 32, "mid_rst_weight");
    expect_at(1, SelSpre, 0, "mid_rst_spike_pre");
    expect_at(1, SelStPre, 0, "mid_rst_state_pre");
    expect_at(1, SelStPst, 0, "mid_rst_state_post");
    step(1);
    n_cmp++;
    if (state_pre !== 8'd0 || weight !== 8'd32) begin
      n_bad++;
      $display("FAIL direct_mid_rst: state_pre=%0d weight=%0d", state_pre, weight);
    end
    rst = 1'b0;
    expect_at(1, SelSpre, 1, "mid_rst_refire");
    step(2);

    for (int k = 0; k < 20 && sb.size() > 0; k++) step(1);
    #1;
    foreach (sb[i]) begin
      n_bad++;
      $display("FAIL %s: never sampled, want %0d", sb[i].name, sb[i].val);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
